mult_seq: RTL

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mult_seq.sv
// mult_seq: sequential radix-2 signed multiplier for Q2.11 operands.
//
// One multiply takes 14 CALC cycles (one partial product per clock) followed
// by a single DONE cycle. Results are registered and held until the next
// operation completes.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     begin a multiply (only honoured in IDLE)
//   a, b      signed Q2.11 operands, captured on the accepting edge
//   busy      high in CALC and DONE
//   done      one-cycle pulse in DONE, when the result registers have updated
//   p_full    full 28-bit signed product
//   prod      Q2.11 product window p_full[24:11]
//   prod_msb  p_full[27:25], overflow guard bits for the downstream saturator
//   a13, b13  operand sign bits of the operation that produced the result
//   state_dbg current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: start is a level request sampled only while idle; a request
// raised while busy is dropped, not queued. done is a single-cycle pulse and
// needs no acknowledge.

module mult_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] a,
    input  logic [13:0] b,
    output logic        busy,
    output logic        done,
    output logic [27:0] p_full,
    output logic [13:0] prod,
    output logic [2:0]  prod_msb,
    output logic        a13,
    output logic        b13,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  cnt;
    logic [27:0] acc;
    logic [27:0] acc_next;
    logic [27:0] mcand_sh;   // sign-extended multiplicand, shifted left each step
    logic [13:0] mplier;     // multiplier, shifted right each step
    logic [27:0] pp;
    logic        a_sign_q;
    logic        b_sign_q;
    logic [27:0] p_full_q;
    logic        a13_q;
    logic        b13_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == 4'd13) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    // Multiplier bit i weighs +2^i except the sign bit, which weighs -2^13,
    // so the last partial product is subtracted instead of added. Mod 2^28
    // this is exact for every operand pair, including -8192 * -8192.
    always_comb begin
        pp       = mplier[0] ? mcand_sh : 28'd0;
        acc_next = (cnt == 4'd13) ? (acc - pp) : (acc + pp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 4'd0;
            acc      <= 28'd0;
            mcand_sh <= 28'd0;
            mplier   <= 14'd0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            p_full_q <= 28'd0;
            a13_q    <= 1'b0;
            b13_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand_sh <= {{14{a[13]}}, a};
                        mplier   <= b;
                        a_sign_q <= a[13];
                        b_sign_q <= b[13];
                        acc      <= 28'd0;
                        cnt      <= 4'd0;
                    end
                end
                CALC: begin
                    acc      <= acc_next;
                    mcand_sh <= mcand_sh << 1;
                    mplier   <= mplier >> 1;
                    if (cnt == 4'd13) begin
                        // All result registers change together on entry to DONE.
                        cnt      <= 4'd0;
                        p_full_q <= acc_next;
                        a13_q    <= a_sign_q;
                        b13_q    <= b_sign_q;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign p_full    = p_full_q;
    assign prod      = p_full_q[24:11];
    assign prod_msb  = p_full_q[27:25];
    assign a13       = a13_q;
    assign b13       = b13_q;
    assign state_dbg = state;

endmodule
